neuron_acc_ctrl: RTL and testbench
==================================

NEURON_ACC_CTRL -- requirements
Module: neuron_acc_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 32: operand and sum width, signed two's complement.
REQ-002 SHALL have parameter frac, default 24: fractional bits (Q8.24); pass-through only, with no scaling inside the block.
REQ-003 SHALL have parameter NPAIR, default 392: operand pairs per neuron sum (784 inputs).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: begin a new sum; sampled only in IDLE.
REQ-007 SHALL have port bias, input, DWIDTH bits: initial accumulator value, captured on an accepted start.
REQ-008 SHALL have port in_valid, input, 1 bit: an operand pair is present.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts a pair this cycle.
REQ-010 SHALL have port in_a and port in_b, input, DWIDTH bits each: the two operands (weighted products).
REQ-011 SHALL have port sum_out, output, DWIDTH bits: the final neuron sum.
REQ-012 SHALL have port sum_valid, output, 1 bit: one-cycle pulse when sum_out is new.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 SHALL implement the states IDLE, LOAD, ACC and DONE in a registered FSM.
REQ-015 IDLE: when start=1, SHALL capture bias into acc and go to LOAD; otherwise stay in IDLE.
REQ-016 LOAD: SHALL clear the pair counter and go to ACC after exactly 1 cycle; in_ready=0 in this state.
REQ-017 ACC: SHALL drive in_ready=1; on in_valid&in_ready, SHALL set acc <= acc + in_a + in_b and increment the counter.
REQ-018 The update in REQ-017 SHALL have 1-cycle latency, with one pair per cycle at full throughput.
REQ-019 ACC: when the accepted pair is pair NPAIR-1, SHALL go to DONE on the next edge; in_ready SHALL fall in the same cycle the state becomes DONE.
REQ-020 ACC with in_valid=0: SHALL hold acc and the counter (stall), with no timeout.
REQ-021 DONE: SHALL set sum_out <= acc and assert sum_valid for exactly 1 cycle, then go to IDLE.
REQ-022 sum_out SHALL hold its value until the next DONE.
REQ-023 Arithmetic SHALL be a DWIDTH-bit wrap-around sum with no saturation, matching the team adder; intermediate carries are discarded.
REQ-024 start SHALL be ignored while busy=1, and a start in the same cycle as the DONE pulse SHALL also be ignored.
REQ-025 start held high SHALL begin a new sum in the first IDLE cycle after DONE.
REQ-026 in_valid outside ACC SHALL be ignored; no pair is consumed.
REQ-027 The counter SHALL be $clog2(NPAIR+1) bits wide and SHALL never wrap within a sum.

Reset
REQ-028 rst=1 SHALL asynchronously force: state=IDLE, acc=0, counter=0, sum_out=0, sum_valid=0, in_ready=0, busy=0.
REQ-029 Reset mid-sum SHALL abandon the partial sum with no sum_valid pulse; operation resumes at the first clk edge after rst deasserts.

Structure
REQ-030 The state encoding, DWIDTH/frac defaults and NPAIR default SHALL reside in the shared NN package.
REQ-031 The block SHALL instantiate exactly one sub-module, adder_4in (three-input adder), with A=acc, B=in_a, C=in_b; there SHALL be no other adders.
REQ-032 The RTL SHALL contain no multipliers and no RAM.

Verification
REQ-033 NPAIR=4, bias=0x01000000, pairs (0x00800000,0x00800000)x4 with in_valid always high -> sum_valid pulses 6 cycles after the start cycle, and sum_out=0x05000000.
REQ-034 Same stimulus with in_valid low for 3 cycles between pairs 2 and 3 -> sum_out=0x05000000, with sum_valid delayed by exactly 3 cycles.
REQ-035 bias=0x7F000000, one pair (0x01000000,0x01000000), NPAIR=1 -> sum_out=0x81000000 (wrap, no saturation).
REQ-036 Negative operands: bias=0, pairs (0xFF000000,0x00000000)x4 -> sum_out=0xFC000000 (-4.0).
REQ-037 rst pulsed after pair 2 -> no sum_valid; all outputs are 0 at once; a subsequent start with bias=0 and four (0,0) pairs -> sum_out=0.
REQ-038 start re-asserted during ACC and during the DONE cycle -> ignored; exactly one sum_valid per accepted start.

Source files
------------

// File: rtl/neuron_acc_ctrl_pkg.sv
// Shared NN package: datapath defaults and the accumulator controller state encoding.
package neuron_acc_ctrl_pkg;

    localparam int NN_DWIDTH = 32;   // Q8.24 operands and sums
    localparam int NN_FRAC   = 24;
    localparam int NN_NPAIR  = 392;  // 784 inputs taken two per cycle

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/neuron_acc_ctrl_adder_4in.sv
// Three-operand wrap-around adder shared across the NN datapath; carries beyond WIDTH are dropped.
module adder_4in #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    output logic [WIDTH-1:0] o_sum
);

    assign o_sum = i_a + i_b + i_c;

endmodule

// File: rtl/neuron_acc_ctrl.sv
// Neuron sum controller: loads a bias, accumulates NPAIR operand pairs one per cycle,
// then presents the wrapped DWIDTH-bit sum with a one-cycle sum_valid pulse.
module neuron_acc_ctrl
    import neuron_acc_ctrl_pkg::*;
#(
    parameter int DWIDTH = NN_DWIDTH,
    parameter int frac   = NN_FRAC,
    parameter int NPAIR  = NN_NPAIR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DWIDTH-1:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_a,
    input  logic [DWIDTH-1:0] in_b,
    output logic [DWIDTH-1:0] sum_out,
    output logic              sum_valid,
    output logic              busy,
    output state_t            dbg_state
);

    localparam int CW = $clog2(NPAIR + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NPAIR - 1);

    generate
        if (frac < 0 || frac >= DWIDTH) begin : g_bad_frac
            $error("neuron_acc_ctrl: frac must lie in [0, DWIDTH-1]");
        end
        if (NPAIR < 1) begin : g_bad_npair
            $error("neuron_acc_ctrl: NPAIR must be at least 1");
        end
    endgenerate

    state_t            r_state;
    state_t            w_next;
    logic [DWIDTH-1:0] r_acc;
    logic [DWIDTH-1:0] r_sum_out;
    logic              r_sum_valid;
    logic [CW-1:0]     r_cnt;
    logic [DWIDTH-1:0] w_sum;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_last;

    // Handshake: a pair transfers on a rising edge where in_valid && in_ready are both
    // high; in_ready depends only on the registered state, never on in_valid.
    assign w_accept = in_valid & w_in_ready;
    assign w_last   = (r_cnt == LAST_IDX);

    adder_4in #(
        .WIDTH (DWIDTH)
    ) u_adder (
        .i_a   (r_acc),
        .i_b   (in_a),
        .i_c   (in_b),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_next = ST_ACC;
            end
            ST_ACC: begin
                w_in_ready = 1'b1;
                if (in_valid && w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // The final sum is latched on the edge that enters DONE, so sum_out and sum_valid
    // are both visible throughout the DONE cycle (where sum_out equals acc).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sum_out   <= '0;
            r_sum_valid <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_acc <= bias;
            end else if (w_accept) begin
                r_acc <= w_sum;
            end

            if (r_state == ST_LOAD) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + CW'(1);
            end

            r_sum_valid <= w_accept && w_last;
            if (w_accept && w_last) begin
                r_sum_out <= w_sum;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign sum_out   = r_sum_out;
    assign sum_valid = r_sum_valid;
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_neuron_acc_ctrl.sv
// Bench for neuron_acc_ctrl: directed sums on an NPAIR=4 and an NPAIR=1 instance,
// expected sums and pulse cycles queued by the drivers and popped by a monitor.
module tb_neuron_acc_ctrl;
    import neuron_acc_ctrl_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_s    [2];
    logic [W-1:0] bias_s     [2];
    logic         in_valid_s [2];
    logic [W-1:0] in_a_s     [2];
    logic [W-1:0] in_b_s     [2];
    logic         in_ready_s [2];
    logic [W-1:0] sum_out_s  [2];
    logic         sum_valid_s[2];
    logic         busy_s     [2];
    state_t       dbg_s      [2];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    int           exp_dut_q[$];

    // ---------------- clock / reset / DUTs ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    neuron_acc_ctrl #(.DWIDTH(W), .frac(24), .NPAIR(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start_s[0]), .bias(bias_s[0]),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .in_a(in_a_s[0]), .in_b(in_b_s[0]),
        .sum_out(sum_out_s[0]), .sum_valid(sum_valid_s[0]),
        .busy(busy_s[0]), .dbg_state(dbg_s[0])
    );

    neuron_acc_ctrl #(.DWIDTH(W), .frac(24), .NPAIR(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .bias(bias_s[1]),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .in_a(in_a_s[1]), .in_b(in_b_s[1]),
        .sum_out(sum_out_s[1]), .sum_valid(sum_valid_s[1]),
        .busy(busy_s[1]), .dbg_state(dbg_s[1])
    );

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_sum(input int d, input logic [W-1:0] val, input int at_cyc);
        exp_q.push_back(val);
        exp_cyc_q.push_back(at_cyc);
        exp_dut_q.push_back(d);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (sum_valid_s[d]) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_sum_valid dut%0d: sum_out %h at cycle %0d, no sum expected",
                             d, sum_out_s[d], cyc);
                end else begin
                    logic [W-1:0] ev;
                    int ec;
                    int ed;
                    ev = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    ed = exp_dut_q.pop_front();
                    check("sum_dut", W'(d), W'(ed));
                    check("sum_value", sum_out_s[d], ev);
                    check("sum_cycle", W'(cyc), W'(ec));
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic pulse_start(input int d, input logic [W-1:0] b);
        start_s[d] = 1'b1;
        bias_s[d]  = b;
        @(posedge clk); #1;
        start_s[d] = 1'b0;
    endtask

    task automatic send_pair(input int d, input logic [W-1:0] a, input logic [W-1:0] b);
        int k;
        in_valid_s[d] = 1'b1;
        in_a_s[d]     = a;
        in_b_s[d]     = b;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready_s[d]) break;
        end
        if (k == 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout dut%0d: in_ready 0 for 50 cycles, required 1", d);
        end
        @(posedge clk); #1;
        in_valid_s[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy_s[d]) break;
        end
        if (k == 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout dut%0d: busy 1 for 100 cycles, required 0", d);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_outputs_zero(input int d, input string tag);
        check({tag, "_sum_out"}, sum_out_s[d], '0);
        check({tag, "_sum_valid"}, W'(sum_valid_s[d]), '0);
        check({tag, "_in_ready"}, W'(in_ready_s[d]), '0);
        check({tag, "_busy"}, W'(busy_s[d]), '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0; bias_s[d] = '0; in_valid_s[d] = 1'b0;
            in_a_s[d] = '0; in_b_s[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero(0, "reset_dut4");
        check_outputs_zero(1, "reset_dut1");
        rst = 1'b0;
        @(posedge clk); #1;

        // Q8.24: 1.0 + 4 * (0.5 + 0.5) = 5.0, pulse 6 cycles after start
        t0 = cyc;
        expect_sum(0, 32'h0500_0000, t0 + 6);
        pulse_start(0, 32'h0100_0000);
        for (int i = 0; i < 4; i++) send_pair(0, 32'h0080_0000, 32'h0080_0000);
        wait_idle(0);

        // Same sum with a 3-cycle gap between pairs 2 and 3
        t0 = cyc;
        expect_sum(0, 32'h0500_0000, t0 + 9);
        pulse_start(0, 32'h0100_0000);
        send_pair(0, 32'h0080_0000, 32'h0080_0000);
        send_pair(0, 32'h0080_0000, 32'h0080_0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", W'(in_ready_s[0]), W'(1));
            check("stall_busy", W'(busy_s[0]), W'(1));
            @(posedge clk); #1;
        end
        send_pair(0, 32'h0080_0000, 32'h0080_0000);
        send_pair(0, 32'h0080_0000, 32'h0080_0000);
        wait_idle(0);

        // NPAIR=1: 127.0 + 2.0 wraps to 0x81000000
        t0 = cyc;
        expect_sum(1, 32'h8100_0000, t0 + 3);
        pulse_start(1, 32'h7F00_0000);
        send_pair(1, 32'h0100_0000, 32'h0100_0000);
        wait_idle(1);

        // Negative operands: 4 * -1.0 = -4.0
        t0 = cyc;
        expect_sum(0, 32'hFC00_0000, t0 + 6);
        pulse_start(0, 32'h0000_0000);
        for (int i = 0; i < 4; i++) send_pair(0, 32'hFF00_0000, 32'h0000_0000);
        wait_idle(0);

        // Mixed small integers: 0x10 + 1+2+3+4+5+6+7+8 = 0x34
        t0 = cyc;
        expect_sum(0, 32'h0000_0034, t0 + 6);
        pulse_start(0, 32'h0000_0010);
        for (int i = 0; i < 4; i++) send_pair(0, W'(2 * i + 1), W'(2 * i + 2));
        wait_idle(0);

        // Reset after pair 2 abandons the sum and clears outputs immediately
        pulse_start(0, 32'h1234_5678);
        send_pair(0, 32'h0000_1111, 32'h0000_2222);
        send_pair(0, 32'h0000_1111, 32'h0000_2222);
        rst = 1'b1;
        #2;
        check_outputs_zero(0, "midsum_reset");
        check("midsum_reset_state", W'(dbg_s[0]), W'(ST_IDLE));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        t0 = cyc;
        expect_sum(0, 32'h0000_0000, t0 + 6);
        pulse_start(0, 32'h0000_0000);
        for (int i = 0; i < 4; i++) send_pair(0, 32'h0, 32'h0);
        wait_idle(0);

        // start re-asserted during ACC and during DONE is ignored
        t0 = cyc;
        expect_sum(0, 32'h0000_01C0, t0 + 6);
        pulse_start(0, 32'h0000_0100);
        send_pair(0, 32'h10, 32'h20);
        start_s[0] = 1'b1;
        send_pair(0, 32'h10, 32'h20);
        start_s[0] = 1'b0;
        send_pair(0, 32'h10, 32'h20);
        send_pair(0, 32'h10, 32'h20);
        check("done_busy", W'(busy_s[0]), W'(1));
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("ignored_start_busy", W'(busy_s[0]), W'(0));
        check("ignored_start_sum_out", sum_out_s[0], 32'h0000_01C0);

        // start held high: second sum begins in the first IDLE cycle after DONE
        t0 = cyc;
        expect_sum(0, 32'h0000_0008, t0 + 6);
        expect_sum(0, 32'h0000_0008, t0 + 13);
        start_s[0] = 1'b1;
        bias_s[0]  = 32'h0;
        for (int i = 0; i < 5; i++) send_pair(0, 32'h1, 32'h1);
        start_s[0] = 1'b0;
        for (int i = 0; i < 3; i++) send_pair(0, 32'h1, 32'h1);
        wait_idle(0);

        repeat (5) @(posedge clk);
        #1;
        while (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_sum_valid dut%0d: no pulse seen, expected sum %h at cycle %0d",
                     exp_dut_q[0], exp_q[0], exp_cyc_q[0]);
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
            void'(exp_dut_q.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
